uart_8n1: RTL

- Byte-wide UART peripheral for the f8 system: 8 data bits, no parity, 1 stop bit.
- Sits on the system's memory-mapped I/O bus, directly downstream of the serial pin pair (TX/RX), which it drives instead of GPIO bit-banging.
- Holds one TX holding byte and one RX byte; exposes data, status and a 16-bit run-time baud divisor; raises an interrupt request.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_baudgen.sv | 42 ++++
 rtl/uart_8n1.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART: register map, STATUS bit positions,
// the common TX/RX state type and the divisor clamp.
package uart_pkg;

  localparam logic [1:0] UART_DATA   = 2'd0;
  localparam logic [1:0] UART_STATUS = 2'd1;
  localparam logic [1:0] UART_DIVLO  = 2'd2;
  localparam logic [1:0] UART_DIVHI  = 2'd3;

  localparam int ST_TX_READY = 0;
  localparam int ST_RX_VALID = 1;
  localparam int ST_OVERRUN  = 2;
  localparam int ST_FERR     = 3;
  localparam int ST_TX_BUSY  = 4;
  localparam int ST_TX_IE    = 7;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;

  // Bit periods below two cycles would leave no room for a mid-bit sample.
  function automatic logic [15:0] eff_period(input logic [15:0] div);
    return (div < 16'd2) ? 16'd2 : div;
  endfunction

endpackage

// File: rtl/uart_baudgen.sv
// Loadable bit-period down-counter; emits either the end-of-period or the
// mid-period tick, chosen per instance.
module uart_baudgen
  import uart_pkg::*;
#(
  parameter bit HALF = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        restart,
  input  logic [15:0] div,
  output logic        tick
);

  logic [15:0] cnt_q, cnt_d;
  logic [15:0] per_q, per_d;
  logic        full_hit, half_hit;

  always_comb begin
    full_hit = (cnt_q == 16'd0);
    half_hit = (cnt_q == {1'b0, per_q[15:1]});
    tick     = HALF ? half_hit : full_hit;
    per_d    = per_q;
    cnt_d    = cnt_q - 16'd1;
    // The divisor is only picked up here, so a running bit is never shortened.
    if (restart || full_hit) begin
      per_d = eff_period(div);
      cnt_d = per_d - 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 16'd0;
      per_q <= 16'd2;
    end else begin
      cnt_q <= cnt_d;
      per_q <= per_d;
    end
  end

endmodule

// File: rtl/uart_8n1.sv
// Memory-mapped 8N1 UART: one TX holding byte feeding a shifter, one RX byte,
// run-time 16-bit baud divisor and a level interrupt.
module uart_8n1
  import uart_pkg::*;
#(
  parameter logic [15:0] DIVRESET = 16'd208
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] addr,
  input  logic [7:0] wdata,
  input  logic       wr,
  input  logic       rd,
  output logic [7:0] rdata,
  output logic       txd,
  input  logic       rxd,
  output logic       irq
);

  logic [15:0] div_q, div_d;
  logic        tx_ie_q, tx_ie_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  uart_state_e tx_state_q, tx_state_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic [2:0]  tx_idx_q, tx_idx_d;
  logic        txd_q, txd_d;
  logic        rx_meta_q, rx_sync_q, rx_prev_q;
  uart_state_e rx_state_q, rx_state_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [2:0]  rx_idx_q, rx_idx_d;
  logic        rx_bad_q, rx_bad_d;
  logic [7:0]  rx_buf_q, rx_buf_d;
  logic        rx_valid_q, rx_valid_d;
  logic        overrun_q, overrun_d;
  logic        ferr_q, ferr_d;
  logic        tx_restart, tx_tick, rx_restart, rx_tick;
  logic        rx_done, rx_err, status_wr, data_rd;

  uart_baudgen #(.HALF(1'b0)) u_tx_baud (
    .clk(clk), .reset(reset), .restart(tx_restart), .div(div_q), .tick(tx_tick)
  );

  uart_baudgen #(.HALF(1'b1)) u_rx_baud (
    .clk(clk), .reset(reset), .restart(rx_restart), .div(div_q), .tick(rx_tick)
  );

  always_comb begin
    div_d       = div_q;
    tx_ie_d     = tx_ie_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    tx_state_d  = tx_state_q;
    tx_shift_d  = tx_shift_q;
    tx_idx_d    = tx_idx_q;
    txd_d       = txd_q;
    rx_state_d  = rx_state_q;
    rx_shift_d  = rx_shift_q;
    rx_idx_d    = rx_idx_q;
    rx_bad_d    = rx_bad_q;
    rx_buf_d    = rx_buf_q;
    rx_valid_d  = rx_valid_q;
    overrun_d   = overrun_q;
    ferr_d      = ferr_q;
    tx_restart  = 1'b0;
    rx_restart  = 1'b0;
    rx_done     = 1'b0;
    rx_err      = 1'b0;
    status_wr   = wr && (addr == UART_STATUS);
    data_rd     = rd && (addr == UART_DATA) && rx_valid_q;

    if (wr && addr == UART_DIVLO) div_d[7:0]  = wdata;
    if (wr && addr == UART_DIVHI) div_d[15:8] = wdata;
    if (status_wr) tx_ie_d = wdata[ST_TX_IE];
    if (wr && addr == UART_DATA && !hold_full_q) begin
      hold_d      = wdata;
      hold_full_d = 1'b1;
    end

    case (tx_state_q)
      IDLE: if (hold_full_q) begin
        tx_state_d = START;
        txd_d      = 1'b0;
        tx_restart = 1'b1;
      end
      // The holding byte moves to the shifter at the end of the start bit.
      START: if (tx_tick) begin
        tx_shift_d  = hold_q;
        hold_full_d = 1'b0;
        txd_d       = hold_q[0];
        tx_idx_d    = 3'd0;
        tx_state_d  = DATA;
      end
      DATA: if (tx_tick) begin
        if (tx_idx_q == 3'd7) begin
          tx_state_d = STOP;
          txd_d      = 1'b1;
        end else begin
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          txd_d      = tx_shift_q[1];
          tx_idx_d   = tx_idx_q + 3'd1;
        end
      end
      STOP: if (tx_tick) begin
        tx_state_d = hold_full_q ? START : IDLE;
        txd_d      = !hold_full_q;
      end
      default: tx_state_d = IDLE;
    endcase

    case (rx_state_q)
      IDLE: if (rx_prev_q && !rx_sync_q) begin
        rx_state_d = START;
        rx_restart = 1'b1;
        rx_bad_d   = 1'b0;
      end
      START: if (rx_tick) begin
        rx_state_d = rx_sync_q ? IDLE : DATA;
        rx_idx_d   = 3'd0;
      end
      DATA: if (rx_tick) begin
        rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
        rx_idx_d   = rx_idx_q + 3'd1;
        if (rx_idx_q == 3'd7) rx_state_d = STOP;
      end
      STOP: begin
        // After a framing error, hold off until the line is back high.
        if (rx_bad_q) begin
          if (rx_sync_q) begin
            rx_bad_d   = 1'b0;
            rx_state_d = IDLE;
          end
        end else if (rx_tick) begin
          if (rx_sync_q) begin
            rx_done    = 1'b1;
            rx_state_d = IDLE;
          end else begin
            rx_err   = 1'b1;
            rx_bad_d = 1'b1;
          end
        end
      end
      default: rx_state_d = IDLE;
    endcase

    if (status_wr && wdata[ST_OVERRUN]) overrun_d = 1'b0;
    if (status_wr && wdata[ST_FERR])    ferr_d    = 1'b0;
    if (rx_err) ferr_d = 1'b1;
    if (rx_done) begin
      rx_buf_d   = rx_shift_q;
      rx_valid_d = 1'b1;
      if (rx_valid_q && !data_rd) overrun_d = 1'b1;
    end else if (data_rd) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q       <= DIVRESET;
      tx_ie_q     <= 1'b0;
      hold_q      <= 8'd0;
      hold_full_q <= 1'b0;
      tx_state_q  <= IDLE;
      tx_shift_q  <= 8'd0;
      tx_idx_q    <= 3'd0;
      txd_q       <= 1'b1;
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_state_q  <= IDLE;
      rx_shift_q  <= 8'd0;
      rx_idx_q    <= 3'd0;
      rx_bad_q    <= 1'b0;
      rx_buf_q    <= 8'd0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      div_q       <= div_d;
      tx_ie_q     <= tx_ie_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      tx_state_q  <= tx_state_d;
      tx_shift_q  <= tx_shift_d;
      tx_idx_q    <= tx_idx_d;
      txd_q       <= txd_d;
      rx_meta_q   <= rxd;
      rx_sync_q   <= rx_meta_q;
      rx_prev_q   <= rx_sync_q;
      rx_state_q  <= rx_state_d;
      rx_shift_q  <= rx_shift_d;
      rx_idx_q    <= rx_idx_d;
      rx_bad_q    <= rx_bad_d;
      rx_buf_q    <= rx_buf_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      ferr_q      <= ferr_d;
    end
  end

  always_comb begin
    case (addr)
      UART_DATA:   rdata = rx_buf_q;
      UART_STATUS: rdata = {tx_ie_q, 2'b00, (tx_state_q != IDLE), ferr_q,
                            overrun_q, rx_valid_q, !hold_full_q};
      UART_DIVLO:  rdata = div_q[7:0];
      default:     rdata = div_q[15:8];
    endcase
  end

  assign txd = txd_q;
  assign irq = rx_valid_q | (!hold_full_q & tx_ie_q);

endmodule
